// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer.
//   rst_state_e : sequencer FSM states
//   max()       : integer maximum, used to size the shared down-counter
package rst_pkg;

    typedef enum logic [2:0] {
        HOLD,
        STRETCH,
        RELEASE,
        RUN,
        SWRST
    } rst_state_e;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Reset deassertion synchroniser.
// Asserts immediately (async clear of the whole chain); deasserts only after
// a 1 has walked through SYNC_STAGES flops on clk.
//   clk      : clock
//   rst_n    : asynchronous active-low reset input
//   rst_sync : synchronised "out of reset" level (1 = released)
module rst_sync
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync
);

    if (SYNC_STAGES < 2) begin : g_param_check
        $error("rst_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] chain_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer.
// After rst_n deassertion is synchronised, the outputs are held for STRETCH
// cycles, then rst_out[0..NUM_OUT-1] are released one by one, GAP cycles
// apart. A rising edge on sw_req while in RUN replays the same sequence and
// finishes with a one-cycle sw_ack.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   sw_req  : software reset request (rising edge triggers, only in RUN)
//   sw_ack  : one-cycle pulse when a software sequence completes
//   rst_out : sequenced resets, polarity set by ACTIVE_HIGH, bit 0 first
//   ready   : all outputs released and sequencer in RUN
module rst_seq
    import rst_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_req,
    output logic               sw_ack,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready
);

    if (STRETCH < 1 || GAP < 1 || NUM_OUT < 1 || SYNC_STAGES < 2) begin : g_param_check
        $error("rst_seq: illegal parameter set");
    end

    localparam int CNT_W = $clog2(max(STRETCH, GAP) + 1);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic             ASSERTED     = (ACTIVE_HIGH != 0);
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_OUT);

    logic             rst_sync_lvl;
    rst_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             sw_req_reg;
    // Remembers that the sequence in flight was software-initiated, since
    // the SWRST state itself is left long before the ack is due.
    logic             sw_seq_reg;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_sync (rst_sync_lvl)
    );

    // The counter is loaded with N-1 so that the action happens on the N-th
    // edge after the load, when the counter is seen at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= HOLD;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            sw_req_reg <= 1'b0;
            sw_seq_reg <= 1'b0;
            rst_out    <= {NUM_OUT{ASSERTED}};
            ready      <= 1'b0;
            sw_ack     <= 1'b0;
        end else begin
            sw_req_reg <= sw_req;
            sw_ack     <= 1'b0;
            case (state_reg)
                HOLD: begin
                    if (rst_sync_lvl) begin
                        state_reg <= rst_pkg::STRETCH;
                        cnt_reg   <= STRETCH_LOAD;
                    end
                end
                rst_pkg::STRETCH, SWRST: begin
                    if (cnt_reg == '0) begin
                        rst_out[0] <= ~ASSERTED;
                        idx_reg    <= IDX_W'(1);
                        cnt_reg    <= GAP_LOAD;
                        state_reg  <= RELEASE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg  <= RUN;
                        ready      <= 1'b1;
                        sw_ack     <= sw_seq_reg;
                        sw_seq_reg <= 1'b0;
                    end else if (cnt_reg == '0) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (idx_reg == IDX_W'(i)) begin
                                rst_out[i] <= ~ASSERTED;
                            end
                        end
                        idx_reg <= idx_reg + IDX_W'(1);
                        cnt_reg <= GAP_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (sw_req && !sw_req_reg) begin
                        state_reg  <= SWRST;
                        rst_out    <= {NUM_OUT{ASSERTED}};
                        ready      <= 1'b0;
                        cnt_reg    <= STRETCH_LOAD;
                        idx_reg    <= '0;
                        sw_seq_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: two instances share rst_n/sw_req, one with default
// parameters and one with ACTIVE_HIGH=0, NUM_OUT=1, STRETCH=1, GAP=1.
// The reference model counts edges: after rst_n rises, SYNC_STAGES edges
// fill the synchroniser and the next edge is E0 (the first edge that sees
// rst_sync=1). From the start k=0 of a sequence (E0 or the SWRST entry edge)
// bit i is released once k >= STRETCH + i*GAP, and ready is 1 once
// k >= STRETCH + (NUM_OUT-1)*GAP + 1.
module tb_rst_seq;

    localparam int SYNC = 2;
    localparam int N0 = 4, S0 = 16, G0 = 4;
    localparam int N1 = 1, S1 = 1,  G1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw_req = 1'b0;
    logic       sw_ack0, ready0, sw_ack1, ready1;
    logic [3:0] rst_out0;
    logic [0:0] rst_out1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rst_seq dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_req  (sw_req),
        .sw_ack  (sw_ack0),
        .rst_out (rst_out0),
        .ready   (ready0)
    );

    rst_seq #(
        .NUM_OUT     (N1),
        .SYNC_STAGES (SYNC),
        .STRETCH     (S1),
        .GAP         (G1),
        .ACTIVE_HIGH (0)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_req  (sw_req),
        .sw_ack  (sw_ack1),
        .rst_out (rst_out1),
        .ready   (ready1)
    );

    // ---------------- reference model ----------------
    int m_sync [2];
    int m_k    [2];
    bit m_started [2];
    bit m_sw   [2];
    bit m_prev [2];
    bit m_ack  [2];

    function automatic int t_ready(input int n, input int s, input int g);
        return s + (n - 1) * g + 1;
    endfunction

    function automatic void m_reset(input int u);
        m_sync[u]    = 0;
        m_k[u]       = 0;
        m_started[u] = 1'b0;
        m_sw[u]      = 1'b0;
        m_prev[u]    = 1'b0;
        m_ack[u]     = 1'b0;
    endfunction

    function automatic void m_step(input int u, input int n, input int s, input int g);
        int tr;
        tr = t_ready(n, s, g);
        m_ack[u] = 1'b0;
        if (!m_started[u]) begin
            if (m_sync[u] >= SYNC) begin
                m_started[u] = 1'b1;
                m_k[u]       = 0;
                m_sw[u]      = 1'b0;
            end else begin
                m_sync[u]++;
            end
        end else if (m_k[u] >= tr && sw_req && !m_prev[u]) begin
            m_k[u]  = 0;
            m_sw[u] = 1'b1;
        end else begin
            if (m_k[u] < 100000) m_k[u]++;
            if (m_k[u] == tr && m_sw[u]) m_ack[u] = 1'b1;
        end
        m_prev[u] = sw_req;
    endfunction

    function automatic logic [3:0] rel_mask(input bit started, input int k,
                                            input int n, input int s, input int g);
        logic [3:0] m;
        m = '0;
        if (started) begin
            for (int i = 0; i < n; i++) begin
                if (k >= s + i * g) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, N0, S0, G0);
            m_step(1, N1, S1, G1);
        end
    end

    // ---------------- checking ----------------
    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] m0, m1;
        bit         r0, r1;
        m0 = rel_mask(m_started[0], m_k[0], N0, S0, G0);
        m1 = rel_mask(m_started[1], m_k[1], N1, S1, G1);
        r0 = m_started[0] && (m_k[0] >= t_ready(N0, S0, G0));
        r1 = m_started[1] && (m_k[1] >= t_ready(N1, S1, G1));
        check4("model_rst_out0", rst_out0, ~m0);
        check1("model_ready0", ready0, r0);
        check1("model_sw_ack0", sw_ack0, m_ack[0]);
        check1("model_rst_out1", rst_out1[0], m1[0]);
        check1("model_ready1", ready1, r1);
        check1("model_sw_ack1", sw_ack1, m_ack[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called right after rst_n falls, before any further clk edge.
    task automatic async_chk(input string tag);
        #1;
        check4({tag, "_rst_out0"}, rst_out0, 4'hF);
        check1({tag, "_ready0"}, ready0, 1'b0);
        check1({tag, "_sw_ack0"}, sw_ack0, 1'b0);
        check1({tag, "_rst_out1"}, rst_out1[0], 1'b0);
        check1({tag, "_ready1"}, ready1, 1'b0);
    endtask

    // Releases rst_n mid-cycle (two units after a posedge).
    task automatic release_rst();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int hold;
        #1 rst_n = 1'b0;

        // 1: power-on with defaults
        tick(5);
        check4("por_hold_rst_out0", rst_out0, 4'hF);
        #1 rst_n = 1'b1;
        tick(3);
        check1("p1_e0_rst_out1", rst_out1[0], 1'b0);
        tick(1);
        check1("p1_e1_rst_out1", rst_out1[0], 1'b1);
        check1("p1_e1_ready1", ready1, 1'b0);
        tick(1);
        check1("p1_e2_ready1", ready1, 1'b1);
        tick(13);
        check4("por_e15", rst_out0, 4'hF);
        tick(1);
        check4("por_e16", rst_out0, 4'hE);
        tick(4);
        check4("por_e20", rst_out0, 4'hC);
        tick(4);
        check4("por_e24", rst_out0, 4'h8);
        tick(4);
        check4("por_e28", rst_out0, 4'h0);
        check1("por_e28_ready", ready0, 1'b0);
        tick(1);
        check1("por_e29_ready", ready0, 1'b1);
        check1("por_e29_ack", sw_ack0, 1'b0);

        // 2: software reset, sw_req high for 3 cycles
        tick(2);
        sw_req = 1'b1;
        tick(1);
        check4("sw_entry_rst_out0", rst_out0, 4'hF);
        check1("sw_entry_ready", ready0, 1'b0);
        tick(2);
        sw_req = 1'b0;
        tick(27);
        check1("sw_s29_ready", ready0, 1'b1);
        check1("sw_s29_ack", sw_ack0, 1'b1);
        tick(1);
        check1("sw_s30_ack", sw_ack0, 1'b0);

        // 3: sw_req raised during power-on RELEASE, held past RUN entry
        rst_n = 1'b0;
        async_chk("t3");
        tick(2);
        release_rst();
        tick(3 + 18);
        sw_req = 1'b1;
        tick(20);
        check1("held_req_ready", ready0, 1'b1);
        check1("held_req_ack", sw_ack0, 1'b0);
        sw_req = 1'b0;
        tick(2);
        sw_req = 1'b1;
        tick(1);
        check4("reraise_rst_out0", rst_out0, 4'hF);
        sw_req = 1'b0;
        tick(35);

        // 4: rst_n asserted between releases and during SWRST
        rst_n = 1'b0;
        async_chk("t4a");
        tick(2);
        release_rst();
        tick(3 + 22);
        rst_n = 1'b0;
        async_chk("t4b");
        tick(3);
        #1 rst_n = 1'b1;
        tick(40);
        sw_req = 1'b1;
        tick(2);
        sw_req = 1'b0;
        tick(8);
        rst_n = 1'b0;
        async_chk("t4c");
        tick(2);
        #1 rst_n = 1'b1;
        tick(40);

        // 6: sub-cycle glitch while in RUN
        #1 rst_n = 1'b0;
        async_chk("t6");
        #1 rst_n = 1'b1;
        tick(40);

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            tick(1);
            r = $urandom_range(0, 199);
            if (r < 20) begin
                sw_req = ~sw_req;
            end else if (r == 20) begin
                rst_n = 1'b0;
                async_chk("rnd");
                hold = $urandom_range(0, 3);
                if (hold == 0) begin
                    #1 rst_n = 1'b1;
                end else begin
                    tick(hold);
                    #1 rst_n = 1'b1;
                end
            end
        end
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
